// File: rtl/bp_fe_queue_rollback_fifo_if.sv
// ---------------------------------------------------------------------------
// bp_fe_queue_rollback_fifo_if
//   Bundles the fe_queue handshake between the FE fetch pipeline, the
//   rollback FIFO and the BE consumer.
//   Producer side : clr_i, fe_queue_i, fe_queue_v_i -> fe_queue_ready_o
//   Consumer side : fe_queue_o, fe_queue_v_o <- fe_queue_yumi_i,
//                   fe_queue_deq_i, fe_queue_roll_i
//   modport master : the environment driving the queue (FE + BE)
//   modport slave  : the rollback FIFO itself
// ---------------------------------------------------------------------------
interface bp_fe_queue_rollback_fifo_if #(
    parameter int width_p = 8
);
    logic               clr_i;
    logic [width_p-1:0] fe_queue_i;
    logic               fe_queue_v_i;
    logic               fe_queue_ready_o;
    logic [width_p-1:0] fe_queue_o;
    logic               fe_queue_v_o;
    logic               fe_queue_yumi_i;
    logic               fe_queue_deq_i;
    logic               fe_queue_roll_i;

    modport master (
        output clr_i, fe_queue_i, fe_queue_v_i,
        output fe_queue_yumi_i, fe_queue_deq_i, fe_queue_roll_i,
        input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
    );

    modport slave (
        input  clr_i, fe_queue_i, fe_queue_v_i,
        input  fe_queue_yumi_i, fe_queue_deq_i, fe_queue_roll_i,
        output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
    );
endinterface

// File: rtl/bp_fe_queue_rollback_fifo.sv
// ---------------------------------------------------------------------------
// bp_fe_queue_rollback_fifo
//   FE-side holding queue for FE->BE fetch packets. Packets are dispatched
//   speculatively (yumi), committed (deq) and replayed from the oldest
//   uncommitted entry (roll).
//   Ports:
//     clk_i    : clock
//     reset_i  : synchronous active-high reset
//     fq       : bp_fe_queue_rollback_fifo_if.slave (see interface file)
//   Three pointers of $clog2(els_p)+1 bits, MSB is the wrap bit:
//     wptr : next slot to write
//     rptr : speculative read pointer (next packet to dispatch)
//     cptr : checkpoint, oldest uncommitted packet
//   Space is reclaimed only on commit, so a dispatched-but-uncommitted packet
//   is never overwritten and can always be replayed.
// ---------------------------------------------------------------------------
module bp_fe_queue_rollback_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bp_fe_queue_rollback_fifo_if.slave    fq
);
    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;
    localparam logic [ptr_w_lp-1:0] ptr_one_lp  = ptr_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] ptr_zero_lp = ptr_w_lp'(0);

    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] cptr_q, cptr_d;

    logic [width_p-1:0]  mem_q [els_p];

    logic                full_s;
    logic                ready_s;
    logic                valid_s;
    logic                enq_s;

    // Full when write and checkpoint share an index but sit on different laps;
    // occupancy is measured against cptr so uncommitted slots stay reserved.
    always_comb begin
        full_s  = (wptr_q[idx_w_lp-1:0] == cptr_q[idx_w_lp-1:0])
               && (wptr_q[idx_w_lp] != cptr_q[idx_w_lp]);
        ready_s = ~reset_i & ~full_s;
        valid_s = ~reset_i & (rptr_q != wptr_q);
        enq_s   = fq.fe_queue_v_i & ready_s & ~fq.clr_i;
    end

    // Pointer next-state: clr wipes everything, roll beats yumi, and roll
    // rewinds to the checkpoint after any same-cycle commit.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (fq.clr_i) begin
            wptr_d = ptr_zero_lp;
            rptr_d = ptr_zero_lp;
            cptr_d = ptr_zero_lp;
        end else begin
            if (enq_s) begin
                wptr_d = wptr_q + ptr_one_lp;
            end else begin
                wptr_d = wptr_q;
            end
            if (fq.fe_queue_deq_i) begin
                cptr_d = cptr_q + ptr_one_lp;
            end else begin
                cptr_d = cptr_q;
            end
            if (fq.fe_queue_roll_i) begin
                rptr_d = cptr_d;
            end else if (fq.fe_queue_yumi_i) begin
                rptr_d = rptr_q + ptr_one_lp;
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= ptr_zero_lp;
            rptr_q <= ptr_zero_lp;
            cptr_q <= ptr_zero_lp;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Packet storage; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_q[wptr_q[idx_w_lp-1:0]] <= fq.fe_queue_i;
        end
    end

    assign fq.fe_queue_ready_o = ready_s;
    assign fq.fe_queue_v_o     = valid_s;
    assign fq.fe_queue_o       = mem_q[rptr_q[idx_w_lp-1:0]];

    bp_fe_queue_rollback_fifo_chk #(
        .els_p   (els_p),
        .ptr_w_p (ptr_w_lp)
    ) u_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (fq.clr_i),
        .yumi_i  (fq.fe_queue_yumi_i),
        .deq_i   (fq.fe_queue_deq_i),
        .v_i     (valid_s),
        .wptr_i  (wptr_q),
        .rptr_i  (rptr_q),
        .cptr_i  (cptr_q)
    );
endmodule

// ---------------------------------------------------------------------------
// bp_fe_queue_rollback_fifo_chk
//   Protocol and pointer-invariant assertions for the rollback FIFO.
//   Inputs: clock/reset, clr/yumi/deq controls, current v_o, and the three
//   pointers. Produces no outputs.
// ---------------------------------------------------------------------------
module bp_fe_queue_rollback_fifo_chk #(
    parameter int els_p   = 8,
    parameter int ptr_w_p = 4
) (
    input logic               clk_i,
    input logic               reset_i,
    input logic               clr_i,
    input logic               yumi_i,
    input logic               deq_i,
    input logic               v_i,
    input logic [ptr_w_p-1:0] wptr_i,
    input logic [ptr_w_p-1:0] rptr_i,
    input logic [ptr_w_p-1:0] cptr_i
);
    localparam logic [ptr_w_p-1:0] els_lp = ptr_w_p'(els_p);

    logic [ptr_w_p-1:0] occ_s;
    logic [ptr_w_p-1:0] spec_s;

    // Modular distances from the checkpoint.
    always_comb begin
        occ_s  = wptr_i - cptr_i;
        spec_s = rptr_i - cptr_i;
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i |-> v_i)
        else $error("yumi asserted without a valid packet");

    a_deq_needs_dispatched: assert property (@(posedge clk_i) disable iff (reset_i)
        (deq_i && !clr_i) |-> ((cptr_i != rptr_i) || yumi_i))
        else $error("deq asserted with nothing dispatched");

    a_ptr_order: assert property (@(posedge clk_i) disable iff (reset_i)
        (occ_s <= els_lp) && (spec_s <= occ_s))
        else $error("pointer ordering cptr <= rptr <= wptr violated");
endmodule

// File: tb/tb_bp_fe_queue_rollback_fifo.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_queue_rollback_fifo
//   Directed, table-driven bench for the rollback FIFO (els_p=4, width_p=8).
//   Each vector drives one cycle of inputs and lists the outputs expected
//   during that cycle (they reflect state before the vector's edge).
//   ctl = {reset, clr, v_i, yumi, deq, roll}; ex = {ready, v_o, check_data}.
// ---------------------------------------------------------------------------
module tb_bp_fe_queue_rollback_fifo;
    localparam int width_lp = 8;
    localparam int els_lp   = 4;

    typedef struct {
        logic [5:0] ctl;
        logic [7:0] din;
        logic [2:0] ex;
        logic [7:0] edata;
    } vec_t;

    logic clk_i;
    logic reset_i;
    int   n_checks;
    int   n_pass;
    vec_t tbl [31];

    bp_fe_queue_rollback_fifo_if #(.width_p(width_lp)) fq ();

    bp_fe_queue_rollback_fifo #(
        .width_p (width_lp),
        .els_p   (els_lp)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .fq      (fq)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic [5:0] ctl, input logic [7:0] din,
                                input logic [2:0] ex, input logic [7:0] edata);
        vec_t v;
        v.ctl   = ctl;
        v.din   = din;
        v.ex    = ex;
        v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one vector just after the edge, check mid-cycle, advance a cycle.
    task automatic apply(input vec_t v, input string nm, input int idx);
        reset_i            = v.ctl[5];
        fq.clr_i           = v.ctl[4];
        fq.fe_queue_v_i    = v.ctl[3];
        fq.fe_queue_yumi_i = v.ctl[2];
        fq.fe_queue_deq_i  = v.ctl[1];
        fq.fe_queue_roll_i = v.ctl[0];
        fq.fe_queue_i      = v.din;
        #4;
        chk({nm, "_ready"}, idx, {7'd0, fq.fe_queue_ready_o}, {7'd0, v.ex[2]});
        chk({nm, "_v"},     idx, {7'd0, fq.fe_queue_v_o},     {7'd0, v.ex[1]});
        if (v.ex[0]) begin
            chk({nm, "_data"}, idx, fq.fe_queue_o, v.edata);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_i            = 1'b1;
        fq.clr_i           = 1'b0;
        fq.fe_queue_v_i    = 1'b0;
        fq.fe_queue_yumi_i = 1'b0;
        fq.fe_queue_deq_i  = 1'b0;
        fq.fe_queue_roll_i = 1'b0;
        fq.fe_queue_i      = 8'h00;
        @(posedge clk_i);
        #1;

        // back-to-back enqueue A1,A2, dispatch both, commit both
        tbl[0]  = mk(6'b100000, 8'h00, 3'b000, 8'h00);
        tbl[1]  = mk(6'b001000, 8'hA1, 3'b100, 8'h00);
        tbl[2]  = mk(6'b001100, 8'hA2, 3'b111, 8'hA1);
        tbl[3]  = mk(6'b000100, 8'h00, 3'b111, 8'hA2);
        tbl[4]  = mk(6'b000010, 8'h00, 3'b100, 8'h00);
        tbl[5]  = mk(6'b000010, 8'h00, 3'b100, 8'h00);
        tbl[6]  = mk(6'b000000, 8'h00, 3'b100, 8'h00);
        // fill to full while dispatching; deq while full blocks the enqueue
        tbl[7]  = mk(6'b001000, 8'hB0, 3'b100, 8'h00);
        tbl[8]  = mk(6'b001100, 8'hB1, 3'b111, 8'hB0);
        tbl[9]  = mk(6'b001100, 8'hB2, 3'b111, 8'hB1);
        tbl[10] = mk(6'b001100, 8'hB3, 3'b111, 8'hB2);
        tbl[11] = mk(6'b001110, 8'hEE, 3'b011, 8'hB3);
        tbl[12] = mk(6'b000000, 8'h00, 3'b100, 8'h00);
        tbl[13] = mk(6'b001000, 8'hB4, 3'b100, 8'h00);
        tbl[14] = mk(6'b000100, 8'h00, 3'b011, 8'hB4);
        tbl[15] = mk(6'b000010, 8'h00, 3'b000, 8'h00);
        tbl[16] = mk(6'b000010, 8'h00, 3'b100, 8'h00);
        tbl[17] = mk(6'b000010, 8'h00, 3'b100, 8'h00);
        tbl[18] = mk(6'b000010, 8'h00, 3'b100, 8'h00);
        // 0x10..0x13 across pointer wrap, 3 yumi, 1 deq, roll, replay
        tbl[19] = mk(6'b001000, 8'h10, 3'b100, 8'h00);
        tbl[20] = mk(6'b001100, 8'h11, 3'b111, 8'h10);
        tbl[21] = mk(6'b001100, 8'h12, 3'b111, 8'h11);
        tbl[22] = mk(6'b001100, 8'h13, 3'b111, 8'h12);
        tbl[23] = mk(6'b000010, 8'h00, 3'b011, 8'h13);
        tbl[24] = mk(6'b000001, 8'h00, 3'b111, 8'h13);
        tbl[25] = mk(6'b000100, 8'h00, 3'b111, 8'h11);
        tbl[26] = mk(6'b000100, 8'h00, 3'b111, 8'h12);
        tbl[27] = mk(6'b000100, 8'h00, 3'b111, 8'h13);
        tbl[28] = mk(6'b000010, 8'h00, 3'b100, 8'h00);
        tbl[29] = mk(6'b000010, 8'h00, 3'b100, 8'h00);
        tbl[30] = mk(6'b000010, 8'h00, 3'b100, 8'h00);

        for (int i = 0; i < 31; i++) begin
            apply(tbl[i], "tbl", i);
        end

        // same-cycle deq+roll with 0x20,0x21 dispatched; yumi that cycle ignored
        apply(mk(6'b001000, 8'h20, 3'b100, 8'h00), "deqroll", 0);
        apply(mk(6'b001100, 8'h21, 3'b111, 8'h20), "deqroll", 1);
        apply(mk(6'b001100, 8'h22, 3'b111, 8'h21), "deqroll", 2);
        apply(mk(6'b000111, 8'h00, 3'b111, 8'h22), "deqroll", 3);
        apply(mk(6'b000100, 8'h00, 3'b111, 8'h21), "deqroll", 4);
        apply(mk(6'b000100, 8'h00, 3'b111, 8'h22), "deqroll", 5);
        apply(mk(6'b000010, 8'h00, 3'b100, 8'h00), "deqroll", 6);
        apply(mk(6'b000010, 8'h00, 3'b100, 8'h00), "deqroll", 7);

        // clr with v_i and yumi on a 3-deep queue; 0x33 must not be stored
        apply(mk(6'b001000, 8'h30, 3'b100, 8'h00), "clr", 0);
        apply(mk(6'b001000, 8'h31, 3'b111, 8'h30), "clr", 1);
        apply(mk(6'b001000, 8'h32, 3'b111, 8'h30), "clr", 2);
        apply(mk(6'b011100, 8'h33, 3'b111, 8'h30), "clr", 3);
        apply(mk(6'b000000, 8'h00, 3'b100, 8'h00), "clr", 4);
        apply(mk(6'b000000, 8'h00, 3'b100, 8'h00), "clr", 5);

        // 1-cycle reset with the queue full and 2 entries speculative
        apply(mk(6'b001000, 8'h40, 3'b100, 8'h00), "rst", 0);
        apply(mk(6'b001100, 8'h41, 3'b111, 8'h40), "rst", 1);
        apply(mk(6'b001100, 8'h42, 3'b111, 8'h41), "rst", 2);
        apply(mk(6'b001000, 8'h43, 3'b111, 8'h42), "rst", 3);
        apply(mk(6'b000000, 8'h00, 3'b011, 8'h42), "rst", 4);
        apply(mk(6'b100000, 8'h00, 3'b000, 8'h00), "rst", 5);
        apply(mk(6'b001000, 8'h50, 3'b100, 8'h00), "rst", 6);
        apply(mk(6'b000000, 8'h00, 3'b111, 8'h50), "rst", 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
